branch_predictor: RTL and testbench

- Parametrised branch target buffer (BTB) with saturating-counter direction prediction for the 5-stage MIPS pipeline.
- Sits beside the program counter: IF looks up the fetch PC combinationally, and ID resolution writes back outcome and target.
- Supports bimodal or gshare indexing, a configurable table depth and counter width, and a registered global history.
- Flags mispredictions and keeps saturating hit/mispredict statistics for the hazard logic and debug.

---
 rtl/branch_predictor_if.sv | 41 ++++
 rtl/branch_predictor.sv | 106 ++++++++++
 tb/tb_branch_predictor.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_if.sv
// ============================================================================
// Module   : branch_predictor_if
// Brief    : IF lookup / ID update bundle between the pipeline and the BTB.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface branch_predictor_if #(
    parameter int HIST_BITS = 4
);
    logic [31:0]          lookup_pc;
    logic                 pred_taken;
    logic [31:0]          pred_target;
    logic [HIST_BITS-1:0] pred_ghr;
    logic                 update_en;
    logic [31:0]          update_pc;
    logic                 update_taken;
    logic [31:0]          update_target;
    logic [HIST_BITS-1:0] update_ghr;
    logic                 update_pred_taken;
    logic [31:0]          update_pred_target;
    logic                 mispredict;
    logic [31:0]          hit_count;
    logic [31:0]          mispredict_count;

    modport master (
        output lookup_pc, update_en, update_pc, update_taken, update_target,
               update_ghr, update_pred_taken, update_pred_target,
        input  pred_taken, pred_target, pred_ghr, mispredict, hit_count,
               mispredict_count
    );

    modport slave (
        input  lookup_pc, update_en, update_pc, update_taken, update_target,
               update_ghr, update_pred_taken, update_pred_target,
        output pred_taken, pred_target, pred_ghr, mispredict, hit_count,
               mispredict_count
    );
endinterface

`default_nettype wire

// File: rtl/branch_predictor.sv
// ============================================================================
// Module   : branch_predictor
// Brief    : Tagged BTB with saturating direction counters, bimodal/gshare.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_predictor #(
    parameter int ENTRIES      = 16,
    parameter int COUNTER_BITS = 2,
    parameter int MODE         = 0,
    parameter int HIST_BITS    = 4
) (
    input  wire logic            clk,
    input  wire logic            rst,
    branch_predictor_if.slave    bus
);
    localparam int c_idx_w = $clog2(ENTRIES);
    localparam int c_tag_w = 30 - c_idx_w;
    localparam logic [COUNTER_BITS-1:0] c_ctr_max     = '1;
    localparam logic [COUNTER_BITS-1:0] c_ctr_weak_t  = COUNTER_BITS'(1 << (COUNTER_BITS-1));
    localparam logic [COUNTER_BITS-1:0] c_ctr_weak_nt = COUNTER_BITS'((1 << (COUNTER_BITS-1)) - 1);

    logic                    r_valid  [ENTRIES];
    logic [c_tag_w-1:0]      r_tag    [ENTRIES];
    logic [29:0]             r_target [ENTRIES];
    logic [COUNTER_BITS-1:0] r_ctr    [ENTRIES];
    logic [HIST_BITS-1:0]    r_ghr;
    logic [31:0]             r_hit_count;
    logic [31:0]             r_mp_count;

    logic [c_idx_w-1:0]   w_lk_hist, w_up_hist;
    logic [c_idx_w-1:0]   w_lk_idx, w_up_idx;
    logic                 w_lk_hit, w_up_hit;
    logic                 w_mispredict;
    logic [HIST_BITS-1:0] w_ghr_next;
    logic                 w_unused_bits;

    // Bimodal ignores history entirely, even a stale snapshot from the caller.
    assign w_lk_hist = (MODE == 1) ? c_idx_w'(r_ghr) : '0;
    assign w_up_hist = (MODE == 1) ? c_idx_w'(bus.update_ghr) : '0;
    assign w_lk_idx  = bus.lookup_pc[c_idx_w+1:2] ^ w_lk_hist;
    assign w_up_idx  = bus.update_pc[c_idx_w+1:2] ^ w_up_hist;

    assign w_lk_hit = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == bus.lookup_pc[31:c_idx_w+2]);
    assign w_up_hit = r_valid[w_up_idx] && (r_tag[w_up_idx] == bus.update_pc[31:c_idx_w+2]);

    assign bus.pred_taken  = !rst && w_lk_hit && r_ctr[w_lk_idx][COUNTER_BITS-1];
    assign bus.pred_target = bus.pred_taken ? {r_target[w_lk_idx], 2'b00}
                                            : bus.lookup_pc + 32'd4;
    assign bus.pred_ghr    = rst ? '0 : r_ghr;

    assign w_mispredict = bus.update_en && !rst &&
                          ((bus.update_taken != bus.update_pred_taken) ||
                           (bus.update_taken && (bus.update_target != bus.update_pred_target)));
    assign bus.mispredict       = w_mispredict;
    assign bus.hit_count        = r_hit_count;
    assign bus.mispredict_count = r_mp_count;

    assign w_unused_bits = ^{bus.lookup_pc[1:0], bus.update_pc[1:0], bus.update_target[1:0]};

    generate
        if (MODE == 1 && HIST_BITS > 1) begin : g_ghr_shift
            assign w_ghr_next = {r_ghr[HIST_BITS-2:0], bus.update_taken};
        end else if (MODE == 1) begin : g_ghr_bit
            assign w_ghr_next = bus.update_taken;
        end else begin : g_ghr_off
            assign w_ghr_next = '0;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i] <= 1'b0;
                r_ctr[i]   <= c_ctr_weak_nt;
            end
            r_ghr       <= '0;
            r_hit_count <= '0;
            r_mp_count  <= '0;
        end else if (bus.update_en) begin
            if (w_up_hit) begin
                if (bus.update_taken) begin
                    if (r_ctr[w_up_idx] != c_ctr_max)
                        r_ctr[w_up_idx] <= r_ctr[w_up_idx] + 1'b1;
                    r_target[w_up_idx] <= bus.update_target[31:2];
                end else if (r_ctr[w_up_idx] != '0) begin
                    r_ctr[w_up_idx] <= r_ctr[w_up_idx] - 1'b1;
                end
            end else if (bus.update_taken) begin
                // Allocation evicts whatever aliased into this slot.
                r_valid[w_up_idx]  <= 1'b1;
                r_tag[w_up_idx]    <= bus.update_pc[31:c_idx_w+2];
                r_target[w_up_idx] <= bus.update_target[31:2];
                r_ctr[w_up_idx]    <= c_ctr_weak_t;
            end
            r_ghr <= w_ghr_next;
            if (w_up_hit && r_hit_count != 32'hFFFF_FFFF)
                r_hit_count <= r_hit_count + 32'd1;
            if (w_mispredict && r_mp_count != 32'hFFFF_FFFF)
                r_mp_count <= r_mp_count + 32'd1;
        end
    end
endmodule

`default_nettype wire

// File: tb/tb_branch_predictor.sv
// ============================================================================
// Module   : tb_branch_predictor
// Brief    : Vector-table + scoreboard bench for bimodal and gshare instances.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_predictor;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic g_rst = 1'b1;
    always #5 clk = ~clk;

    branch_predictor_if #(.HIST_BITS(4)) bi ();
    branch_predictor_if #(.HIST_BITS(4)) gi ();

    branch_predictor #(.ENTRIES(16), .COUNTER_BITS(2), .MODE(0), .HIST_BITS(4)) u_bimodal (
        .clk (clk),
        .rst (rst),
        .bus (bi.slave)
    );

    branch_predictor #(.ENTRIES(16), .COUNTER_BITS(2), .MODE(1), .HIST_BITS(4)) u_gshare (
        .clk (clk),
        .rst (g_rst),
        .bus (gi.slave)
    );

    typedef struct {
        logic        rst;
        logic        upd_en;
        logic [31:0] upd_pc;
        logic        upd_taken;
        logic [31:0] upd_target;
        logic        upd_pred_taken;
        logic [31:0] upd_pred_target;
        logic [31:0] lk_pc;
        logic        exp_taken;
        logic [31:0] exp_target;
        logic        exp_mp;
        logic [31:0] exp_hits;
        logic [31:0] exp_mps;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(input logic r, input logic en, input logic [31:0] pc,
                                input logic tk, input logic [31:0] tgt, input logic ptk,
                                input logic [31:0] ptgt, input logic [31:0] lk,
                                input logic et, input logic [31:0] etg, input logic emp,
                                input logic [31:0] eh, input logic [31:0] em);
        vec_t v;
        v.rst = r; v.upd_en = en; v.upd_pc = pc; v.upd_taken = tk; v.upd_target = tgt;
        v.upd_pred_taken = ptk; v.upd_pred_target = ptgt; v.lk_pc = lk;
        v.exp_taken = et; v.exp_target = etg; v.exp_mp = emp; v.exp_hits = eh; v.exp_mps = em;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic g_step(input logic en, input logic [31:0] pc, input logic tk,
                          input logic [31:0] tgt, input logic [3:0] ughr, input logic [31:0] lk);
        @(posedge clk);
        #1;
        g_rst = 1'b0;
        gi.update_en = en; gi.update_pc = pc; gi.update_taken = tk;
        gi.update_target = tgt; gi.update_ghr = ughr;
        gi.update_pred_taken = 1'b0; gi.update_pred_target = pc + 32'd4;
        gi.lookup_pc = lk;
        @(negedge clk);
    endtask

    initial begin
        vec_t v, e;
        bi.lookup_pc = 32'h40; bi.update_en = 1'b0; bi.update_pc = '0; bi.update_taken = 1'b0;
        bi.update_target = '0; bi.update_ghr = '0; bi.update_pred_taken = 1'b0;
        bi.update_pred_target = '0;
        gi.lookup_pc = '0; gi.update_en = 1'b0; gi.update_pc = '0; gi.update_taken = 1'b0;
        gi.update_target = '0; gi.update_ghr = '0; gi.update_pred_taken = 1'b0;
        gi.update_pred_target = '0;

        //                rst en  upd_pc        tk  target        ptk ptarget       lookup        et  etarget       mp  hits mps
        vecs.push_back(mk(1, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h40,       0, 32'h44,       0, 0, 0));
        vecs.push_back(mk(1, 1, 32'h100,       1, 32'h200,      0, 32'h104,      32'h40,       0, 32'h44,       0, 0, 0));
        vecs.push_back(mk(0, 1, 32'h100,       1, 32'h200,      0, 32'h104,      32'h100,      0, 32'h104,      1, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h100,      1, 32'h200,      0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100,       1, 32'h200,      1, 32'h200,      32'h100,      1, 32'h200,      0, 0, 1));
        vecs.push_back(mk(0, 1, 32'h100,       1, 32'h200,      1, 32'h200,      32'h100,      1, 32'h200,      0, 1, 1));
        vecs.push_back(mk(0, 1, 32'h100,       1, 32'h200,      1, 32'h200,      32'h100,      1, 32'h200,      0, 2, 1));
        vecs.push_back(mk(0, 1, 32'h100,       0, 32'h0,        1, 32'h200,      32'h100,      1, 32'h200,      1, 3, 1));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h100,      1, 32'h200,      0, 4, 2));
        vecs.push_back(mk(0, 1, 32'h100,       0, 32'h0,        1, 32'h200,      32'h100,      1, 32'h200,      1, 4, 2));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h100,      0, 32'h104,      0, 5, 3));
        vecs.push_back(mk(0, 1, 32'h140,       1, 32'h300,      0, 32'h144,      32'h140,      0, 32'h144,      1, 5, 3));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h100,      0, 32'h104,      0, 5, 4));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h140,      1, 32'h300,      0, 5, 4));
        vecs.push_back(mk(0, 1, 32'h140,       1, 32'h400,      1, 32'h300,      32'h140,      1, 32'h300,      1, 5, 4));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h140,      1, 32'h400,      0, 6, 5));
        vecs.push_back(mk(0, 1, 32'h44,        0, 32'h0,        0, 32'h48,       32'h44,       0, 32'h48,       0, 6, 5));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'hFFFF_FFFC, 0, 32'h0,       0, 6, 5));
        vecs.push_back(mk(1, 1, 32'h180,       1, 32'h500,      0, 32'h184,      32'h140,      0, 32'h144,      0, 6, 5));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h140,      0, 32'h144,      0, 0, 0));
        vecs.push_back(mk(0, 0, 32'h0,         0, 32'h0,        0, 32'h0,        32'h180,      0, 32'h184,      0, 0, 0));

        @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            #1;
            v = vecs[i];
            rst = v.rst;
            bi.update_en = v.upd_en; bi.update_pc = v.upd_pc; bi.update_taken = v.upd_taken;
            bi.update_target = v.upd_target; bi.update_ghr = '0;
            bi.update_pred_taken = v.upd_pred_taken; bi.update_pred_target = v.upd_pred_target;
            bi.lookup_pc = v.lk_pc;
            sb.push_back(v);
            @(negedge clk);
            e = sb.pop_front();
            check($sformatf("v%0d.pred_taken", i),  32'(bi.pred_taken), 32'(e.exp_taken));
            check($sformatf("v%0d.pred_target", i), bi.pred_target,     e.exp_target);
            check($sformatf("v%0d.mispredict", i),  32'(bi.mispredict), 32'(e.exp_mp));
            check($sformatf("v%0d.hit_count", i),   bi.hit_count,       e.exp_hits);
            check($sformatf("v%0d.mp_count", i),    bi.mispredict_count, e.exp_mps);
            check($sformatf("v%0d.pred_ghr", i),    32'(bi.pred_ghr),   32'd0);
            @(posedge clk);
        end

        // Gshare: history shifts on every update; index is pc bits XOR history.
        g_step(1'b1, 32'h100, 1'b1, 32'h200, 4'h0, 32'h100);
        check("g1.pred_ghr", 32'(gi.pred_ghr), 32'h0);
        check("g1.mispredict", 32'(gi.mispredict), 32'h1);
        g_step(1'b1, 32'h100, 1'b1, 32'h200, 4'h0, 32'h100);
        check("g2.pred_ghr", 32'(gi.pred_ghr), 32'h1);
        g_step(1'b1, 32'h100, 1'b0, 32'h0, 4'h0, 32'h100);
        check("g3.pred_ghr", 32'(gi.pred_ghr), 32'h3);
        g_step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h100);
        check("g4.pred_ghr", 32'(gi.pred_ghr), 32'h6);
        check("g4.pred_taken", 32'(gi.pred_taken), 32'h0);
        check("g4.pred_target", gi.pred_target, 32'h104);
        check("g4.hit_count", gi.hit_count, 32'd2);
        g_step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h118);
        check("g5.pred_taken", 32'(gi.pred_taken), 32'h1);
        check("g5.pred_target", gi.pred_target, 32'h200);
        g_step(1'b1, 32'h100, 1'b1, 32'h200, 4'h0, 32'h118);
        check("g6.pred_ghr", 32'(gi.pred_ghr), 32'h6);
        g_step(1'b0, 32'h0, 1'b0, 32'h0, 4'h0, 32'h12C);
        check("g7.pred_ghr", 32'(gi.pred_ghr), 32'hD);
        check("g7.hit_count", gi.hit_count, 32'd3);
        check("g7.mp_count", gi.mispredict_count, 32'd3);
        check("g7.pred_taken", 32'(gi.pred_taken), 32'h0);
        check("g7.pred_target", gi.pred_target, 32'h130);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
